// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the MEM-stage data responder: RV32I load/store
// funct3 codes, the responder FSM state encoding and the byte-enable helper.
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte lanes touched by a store of the given size at the given lane.
  // Illegal store sizes touch nothing.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic for the data responder: store byte merge into the
// addressed word, load lane extract with sign/zero extension, and the
// size/alignment legality checks.
module dmem_lane_unit
  import rv32_mem_pkg::*;
(
  input  logic        i_is_load,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_wword,
  output logic [31:0] o_ldata,
  output logic        o_bad_f3,
  output logic        o_misalign
);

  logic [3:0]  w_be;
  logic [31:0] w_wrep;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store path: replicate the right-aligned store data to every lane, then
  // take only the enabled lanes so untouched bytes keep their old value.
  always_comb begin
    w_be = byte_en(i_funct3, i_lane);
    case (i_funct3)
      F3_B:    w_wrep = {4{i_wdata[7:0]}};
      F3_H:    w_wrep = {2{i_wdata[15:0]}};
      default: w_wrep = i_wdata;
    endcase
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) begin
        o_wword[8*b +: 8] = w_wrep[8*b +: 8];
      end else begin
        o_wword[8*b +: 8] = i_rword[8*b +: 8];
      end
    end
  end

  // Load path: pick the addressed byte/halfword and extend it.
  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      2'd3:    w_byte = i_rword[31:24];
      default: w_byte = 8'd0;
    endcase
    if (i_lane[1]) begin
      w_half = i_rword[31:16];
    end else begin
      w_half = i_rword[15:0];
    end
    case (i_funct3)
      F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
      F3_W:    o_ldata = i_rword;
      F3_BU:   o_ldata = {24'd0, w_byte};
      F3_HU:   o_ldata = {16'd0, w_half};
      default: o_ldata = 32'd0;
    endcase
  end

  // Legality: loads allow B/H/W/BU/HU, stores only B/H/W. Halfwords need an
  // even lane, words lane 0 (funct3[1:0] encodes the size for both).
  always_comb begin
    if (i_is_load) begin
      o_bad_f3 = !((i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W) ||
                   (i_funct3 == F3_BU) || (i_funct3 == F3_HU));
    end else begin
      o_bad_f3 = !((i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W));
    end
    case (i_funct3[1:0])
      2'b01:   o_misalign = i_lane[0];
      2'b10:   o_misalign = (i_lane != 2'd0);
      default: o_misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Target side of the MEM-stage data interface: accepts one load/store at a
// time, waits WAIT_CYCLES, accesses a local word array on the edge entering
// RESP and returns a one-cycle response. busy stalls the pipeline meanwhile.
module dmem_responder
  import rv32_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_mr,
  input  logic        req_mw,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_mr;
  logic        r_mw;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_idle;
  logic          w_accept;
  logic          w_go;
  logic          w_mr;
  logic          w_mw;
  logic [2:0]    w_f3;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [31:0]   w_offset;
  logic [AW-1:0] w_idx;
  logic          w_oob;
  logic [31:0]   w_rword;
  logic [31:0]   w_wword;
  logic [31:0]   w_ldata;
  logic          w_bad_f3;
  logic          w_misalign;
  logic          w_err;
  logic          w_we;
  logic [31:0]   w_rdata;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle & req_valid & (req_mr | req_mw);
  // The access happens on the edge entering RESP; with no wait states that
  // is the accept edge itself, so the live request is used instead of the
  // not-yet-captured copy.
  assign w_go     = (w_accept & NO_WAIT) | ((r_state == WAIT) & (r_cnt == 4'd0));

  assign w_mr    = w_idle ? req_mr     : r_mr;
  assign w_mw    = w_idle ? req_mw     : r_mw;
  assign w_f3    = w_idle ? req_funct3 : r_f3;
  assign w_addr  = w_idle ? req_addr   : r_addr;
  assign w_wdata = w_idle ? req_wdata  : r_wdata;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range check.
  assign w_offset = w_addr - BASE_ADDR;
  assign w_idx    = w_offset[AW+1:2];
  assign w_oob    = (w_offset >> (AW + 2)) != 32'd0;
  assign w_rword  = r_mem[w_idx];

  dmem_lane_unit u_lane (
    .i_is_load  (w_mr),
    .i_funct3   (w_f3),
    .i_lane     (w_offset[1:0]),
    .i_rword    (w_rword),
    .i_wdata    (w_wdata),
    .o_wword    (w_wword),
    .o_ldata    (w_ldata),
    .o_bad_f3   (w_bad_f3),
    .o_misalign (w_misalign)
  );

  assign w_err   = (w_mr & w_mw) | w_oob | w_misalign | w_bad_f3;
  assign w_we    = w_go & w_mw & ~w_err;
  assign w_rdata = (w_err | ~w_mr) ? 32'd0 : w_ldata;

  assign req_ready = w_idle;
  assign busy      = (w_accept) | (r_state == WAIT);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // Request capture, wait counter, FSM and registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_mr        <= 1'b0;
      r_mw        <= 1'b0;
      r_f3        <= 3'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_go) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= w_rdata;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mr    <= req_mr;
            r_mw    <= req_mw;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= WAIT_LOAD;
            if (NO_WAIT) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Word array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_idx] <= w_wword;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance for the
// functional scenarios and a WAIT_CYCLES=0 instance for back-to-back traffic.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        req_valid, req_mr, req_mw;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_mr, z_req_mw;
  logic [2:0]  z_req_funct3;
  logic [31:0] z_req_addr, z_req_wdata;
  logic        z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
  logic [31:0] z_rsp_rdata;

  int n_vec  = 0;
  int n_fail = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_mr(req_mr), .req_mw(req_mw),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) dut_z (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_mr(z_req_mr), .req_mw(z_req_mw),
    .req_funct3(z_req_funct3), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .req_ready(z_req_ready), .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .busy(z_busy)
  );

  // Issue one request to the WAIT_CYCLES=2 instance and collect its response.
  // lat counts cycles from the accept cycle to the response cycle; bcnt counts
  // cycles with busy high before the response; rbusy is busy in the response cycle.
  task automatic do_req(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int bcnt, output logic rbusy);
    @(negedge clk);
    req_valid = 1'b1; req_mr = mr; req_mw = mw; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1;
    bcnt = (busy === 1'b1) ? 1 : 0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_mr = ~mr; req_mw = ~mw; req_funct3 = 3'd7; req_addr = ~a; req_wdata = ~wd;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata; er = rsp_err; rbusy = busy;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    n_vec++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_vec++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: valid=%b err=%b busy=%b want 0 0 0", rsp_valid, rsp_err, busy); end
    n_vec++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er, rb; int lat, bc;
    do_req(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat, bc, rb);
    n_vec++; if (lat !== 3) begin n_fail++; $display("FAIL sw_latency: got %0d want 3", lat); end
    n_vec++; if (bc !== 3) begin n_fail++; $display("FAIL sw_busy_cycles: got %0d want 3", bc); end
    n_vec++; if (rb !== 1'b0) begin n_fail++; $display("FAIL sw_busy_in_resp: got %b want 0", rb); end
    n_vec++; if (er !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL sw_rsp: err=%b data=%h want 0 0", er, rd); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_one_cycle: got %b want 0", rsp_valid); end
    do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat, bc, rb);
    n_vec++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL lw_after_sw: got %h err=%b want deadbeef 0", rd, er); end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] adr [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
    logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
    logic [31:0] rd; logic er, rb; int lat, bc;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 1'b0, f3s[i], adr[i], 32'h0, rd, er, lat, bc, rb);
      n_vec++; if (rd !== exp[i] || er !== 1'b0) begin
        n_fail++; $display("FAIL load_ext_%0d: got %h err=%b want %h 0", i, rd, er, exp[i]); end
    end
  endtask

  task automatic test_partial_store;
    logic [31:0] rd; logic er, rb; int lat, bc;
    do_req(1'b0, 1'b1, 3'd0, 32'h11, 32'h12345677, rd, er, lat, bc, rb);
    do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat, bc, rb);
    n_vec++; if (rd !== 32'hDEAD77EF) begin n_fail++; $display("FAIL sb_merge: got %h want dead77ef", rd); end
    do_req(1'b0, 1'b1, 3'd1, 32'h12, 32'h0000ABCD, rd, er, lat, bc, rb);
    do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat, bc, rb);
    n_vec++; if (rd !== 32'hABCD77EF) begin n_fail++; $display("FAIL sh_merge: got %h want abcd77ef", rd); end
  endtask

  task automatic test_errors;
    logic        mrs [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s [4] = '{3'd2, 3'd1, 3'd2, 3'd3};
    logic [31:0] adr [4] = '{32'h11, 32'h13, 32'h1000, 32'h10};
    logic [31:0] rd; logic er, rb; int lat, bc;
    for (int i = 0; i < 4; i++) begin
      do_req(mrs[i], ~mrs[i], f3s[i], adr[i], 32'hFFFFFFFF, rd, er, lat, bc, rb);
      n_vec++; if (er !== 1'b1 || rd !== 32'd0) begin
        n_fail++; $display("FAIL err_case_%0d: err=%b data=%h want 1 0", i, er, rd); end
      do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat, bc, rb);
      n_vec++; if (rd !== 32'hABCD77EF) begin
        n_fail++; $display("FAIL err_no_write_%0d: got %h want abcd77ef", i, rd); end
    end
  endtask

  task automatic test_ignored;
    logic [31:0] rd; logic er, rb; int lat, bc;
    @(negedge clk);
    req_valid = 1'b1; req_mr = 1'b0; req_mw = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_vec++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL no_op_ignored: busy=%b ready=%b valid=%b want 0 1 0", busy, req_ready, rsp_valid); end
    end
    req_valid = 1'b0;
    do_req(1'b1, 1'b1, 3'd2, 32'h10, 32'h0, rd, er, lat, bc, rb);
    n_vec++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL mr_mw_both: err=%b data=%h want 1 0", er, rd); end
    do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat, bc, rb);
    n_vec++; if (rd !== 32'hABCD77EF) begin n_fail++; $display("FAIL mr_mw_no_write: got %h want abcd77ef", rd); end
  endtask

  task automatic test_back_to_back;
    int n_acc, n_rsp; logic [31:0] exp;
    for (int ph = 0; ph < 2; ph++) begin
      n_acc = 0; n_rsp = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        z_req_valid = 1'b1; z_req_mr = (ph == 1); z_req_mw = (ph == 0); z_req_funct3 = 3'd2;
        z_req_addr = 32'h40 + 32'(4 * (c / 2)); z_req_wdata = 32'hA0000000 + 32'(c / 2);
        #1;
        n_vec++; if (z_req_ready !== (c % 2 == 0) || z_rsp_valid !== (c % 2 == 1)) begin
          n_fail++; $display("FAIL b2b_cadence ph%0d c%0d: ready=%b valid=%b", ph, c, z_req_ready, z_rsp_valid); end
        if (z_req_ready === 1'b1) n_acc++;
        if (z_rsp_valid === 1'b1) begin
          n_rsp++;
          exp = (ph == 1) ? 32'hA0000000 + 32'((c - 1) / 2) : 32'd0;
          n_vec++; if (z_rsp_rdata !== exp || z_rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL b2b_data ph%0d c%0d: got %h err=%b want %h 0", ph, c, z_rsp_rdata, z_rsp_err, exp); end
        end
      end
      @(negedge clk); z_req_valid = 1'b0;
      n_vec++; if (n_acc != 8 || n_rsp != 8) begin
        n_fail++; $display("FAIL b2b_count ph%0d: acc=%0d rsp=%0d want 8 8", ph, n_acc, n_rsp); end
    end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] rd; logic er, rb; int lat, bc;
    do_req(1'b0, 1'b1, 3'd2, 32'h20, 32'h11111111, rd, er, lat, bc, rb);
    do_req(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat, bc, rb);
    n_vec++; if (rd !== 32'h11111111) begin n_fail++; $display("FAIL pre_reset_lw: got %h want 11111111", rd); end
    @(negedge clk);
    req_valid = 1'b1; req_mr = 1'b0; req_mw = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_vec++; if (busy !== 1'b1 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL in_wait: busy=%b ready=%b want 1 0", busy, req_ready); end
    #2; reset = 1'b0; #1;
    n_vec++; if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
      n_fail++; $display("FAIL async_reset: ready=%b busy=%b valid=%b err=%b data=%h want 1 0 0 0 0",
                         req_ready, busy, rsp_valid, rsp_err, rsp_rdata); end
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset = 1'b1;
    do_req(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat, bc, rb);
    n_vec++; if (rd !== 32'h11111111) begin n_fail++; $display("FAIL store_dropped: got %h want 11111111", rd); end
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_mr = 1'b0; req_mw = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    z_req_valid = 1'b0; z_req_mr = 1'b0; z_req_mw = 1'b0; z_req_funct3 = 3'd0; z_req_addr = 32'd0; z_req_wdata = 32'd0;
    test_reset;
    test_store_load;
    test_load_ext;
    test_partial_store;
    test_errors;
    test_ignored;
    test_back_to_back;
    test_reset_in_wait;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Target side of the core's MEM-stage data access interface. Accepts one load or store request at a time from the pipeline, inserts a configurable number of wait states, and performs byte, halfword or word access to a local word array. Returns load data, sign- or zero-extended per funct3, with a one-cycle response strobe. Drives a stall line so the hazard logic can freeze the pipeline while an access is outstanding.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)
WAIT_CYCLES, 2, wait states between accept and access (0..15)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_mr  in  1  load request (core mr)
req_mw  in  1  store request (core mw)
req_funct3  in  3  access size/sign, RV32I load/store funct3 encoding
req_addr  in  32  byte address (core ALU result)
req_wdata  in  32  store data (core rs2 value, right-aligned)
req_ready  out  1  responder can accept a request
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  access error, qualified by rsp_valid
busy  out  1  stall request to hazard logic

Behaviour:
- Reset (reset=0, async): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0. Array contents are not reset.
- A request is valid only when exactly one of req_mr/req_mw is 1.
  - req_valid with both low: ignored, no state change.
  - req_valid with both high: accepted and answered with rsp_err=1.
- Accept: req_valid=1 with req_ready=1 (IDLE only). On accept, capture mr, mw, funct3, addr and wdata.
- FSM states: IDLE, WAIT, RESP.
  - IDLE -> WAIT on accept with WAIT_CYCLES>0, loading counter=WAIT_CYCLES-1.
  - IDLE -> RESP on accept with WAIT_CYCLES=0.
  - WAIT: decrement counter; go to RESP when the counter is 0.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. No new accept is possible in RESP.
- Latency: rsp_valid is asserted WAIT_CYCLES+1 cycles after the accept edge. Throughput is one access per WAIT_CYCLES+2 cycles.
- The array access happens on the edge entering RESP.
  - Stores write the array on that edge.
  - Load data and rsp_err are registered on the same edge and held stable while in RESP.
- req_ready = (state==IDLE).
- busy = (state==IDLE & req_valid & (req_mr|req_mw)) | (state==WAIT). busy is low in RESP, so the stalled instruction advances in the same cycle its data is valid.
- Offset = addr - BASE_ADDR. Word index = offset[31:2]. Lane = offset[1:0].
- Loads:
  - funct3 0 (LB): byte sign-extended.
  - funct3 1 (LH): halfword sign-extended.
  - funct3 2 (LW): full word.
  - funct3 4 (LBU): byte zero-extended.
  - funct3 5 (LHU): halfword zero-extended.
  - funct3 3, 6, 7: error.
- Stores: funct3 0 (SB) writes wdata[7:0] into the addressed lane only. Funct3 1 (SH) writes wdata[15:0] into lanes 1:0 or 3:2. Funct3 2 (SW) writes all lanes. Any other funct3: error.
- Errors (rsp_err=1, rsp_rdata=0, array unchanged):
  - Misaligned halfword (lane[0]=1) or word (lane!=0).
  - Offset >= DEPTH_WORDS*4, including addr < BASE_ADDR, which wraps to a large offset.
  - Illegal funct3, or mr and mw both set.
- Byte-lane writes do not modify untouched lanes.
- Request inputs may change freely after the accept; only captured values are used.
- Reset asserted in WAIT or RESP: return to IDLE immediately. A pending store is dropped (no write); a store already written on the RESP edge remains.

Decomposition:
- Package rv32_mem_pkg holds:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - The FSM state enum (IDLE, WAIT, RESP).
  - A helper function computing the 4-bit byte-enable from funct3 and lane.
- One combinational sub-module, dmem_lane_unit, does the store byte-enable/merge, the load lane extract and extension, and the alignment check. The FSM, counter and array stay in dmem_responder.

Test Plan:
- Reset, WAIT_CYCLES=2; SW addr 0x10 data 0xDEADBEEF -> busy=1 for 3 cycles, rsp_valid 3 cycles after accept, rsp_err=0; then LW 0x10 -> rsp_rdata=0xDEADBEEF.
- After the store above: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x11 data 0x12345677 -> LW 0x10 returns 0xDEAD77EF; SH 0x12 data 0x0000ABCD -> LW returns 0xABCD77EF.
- LW 0x11, SH 0x13, LW 0x1000 (DEPTH 1024), funct3=3 load -> each gives rsp_err=1, rsp_rdata=0, and a following LW 0x10 returns 0xABCD77EF.
- WAIT_CYCLES=0 build: back-to-back requests held valid -> rsp_valid every 2nd cycle, req_ready low in RESP, no request lost or doubled.
- SW 0x20 data 0x11111111 completes; SW 0x20 data 0x55AA55AA accepted, reset pulsed low during WAIT -> outputs cleared asynchronously, LW 0x20 after reset returns 0x11111111.
